// File: rtl/branch_unit_if.sv
// ============================================================================
// Module   : branch_unit_if
// Purpose  : Execute-stage branch resolution handshake into branch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface branch_unit_if;
  logic        br_valid;
  logic        br_ready;
  logic        br_taken;
  logic        br_is_rel;
  logic [63:0] br_src_pc;
  logic [63:0] br_offset;
  logic [63:0] br_target;

  modport master (
    output br_valid,
    input  br_ready,
    output br_taken,
    output br_is_rel,
    output br_src_pc,
    output br_offset,
    output br_target
  );

  modport slave (
    input  br_valid,
    output br_ready,
    input  br_taken,
    input  br_is_rel,
    input  br_src_pc,
    input  br_offset,
    input  br_target
  );
endinterface

`default_nettype wire

// File: rtl/branch_unit.sv
// ============================================================================
// Module   : branch_unit
// Purpose  : Resolves taken branches into a one-cycle PC redirect followed by
//            a FLUSH_CYCLES-long fetch/decode squash. Optional BRANCH_STATS_EN
//            adds saturating taken/not-taken counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_unit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  wire              clk,
  input  wire              rst,
  input  wire       [63:0] pc_1,
  branch_unit_if.slave     br,
  output logic      [63:0] pc_branch,
  output logic             redirect,
  output logic             flush
`ifdef BRANCH_STATS_EN
  ,
  output logic      [31:0] stat_taken,
  output logic      [31:0] stat_not_taken
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);
  localparam logic [3:0] FLUSH_LOAD = HAS_FLUSH ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [63:0] tgt_q;
  logic [63:0] tgt_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic        accept;
  logic [63:0] resolved_tgt;

  // Ready only depends on state and rst, so no br_* input reaches an output.
  assign accept       = (state_q == ST_IDLE) && !rst && br.br_valid;
  assign resolved_tgt = br.br_is_rel ? (br.br_src_pc + br.br_offset) : br.br_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= 64'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && br.br_taken) begin
          tgt_d   = resolved_tgt;
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (HAS_FLUSH) begin
          cnt_d   = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pc_branch   = pc_1;
    redirect    = 1'b0;
    flush       = 1'b0;
    br.br_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          br.br_ready = 1'b1;
        end
        ST_REDIRECT: begin
          pc_branch = tgt_q;
          redirect  = 1'b1;
          flush     = 1'b1;
        end
        ST_FLUSH: begin
          flush = 1'b1;
        end
        default: begin
          pc_branch = pc_1;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken     <= 32'd0;
      stat_not_taken <= 32'd0;
    end else if (accept) begin
      if (br.br_taken) begin
        if (stat_taken != 32'hFFFF_FFFF) begin
          stat_taken <= stat_taken + 32'd1;
        end
      end else begin
        if (stat_not_taken != 32'hFFFF_FFFF) begin
          stat_not_taken <= stat_not_taken + 32'd1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
// Module   : tb_branch_unit
// Purpose  : Directed self-checking bench for branch_unit with FLUSH_CYCLES=2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_unit;
  logic        clk;
  logic        rst;
  logic [63:0] pc_1;
  logic [63:0] pc_branch;
  logic        redirect;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
`endif

  int checks;
  int errors;
  int exp_taken;
  int exp_not_taken;

  branch_unit_if bif ();

  branch_unit #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_1           (pc_1),
    .br             (bif),
    .pc_branch      (pc_branch),
    .redirect       (redirect),
    .flush          (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.br_valid  = 1'b0;
    bif.br_taken  = 1'b0;
    bif.br_is_rel = 1'b0;
    bif.br_src_pc = 64'd0;
    bif.br_offset = 64'd0;
    bif.br_target = 64'd0;
  endtask

  // Present one taken branch, accept it on the next edge, then check REDIRECT.
  task automatic taken_branch(input logic is_rel, input logic [63:0] src, input logic [63:0] off,
                              input logic [63:0] tgt, input logic [63:0] exp_pc, input string name);
    bif.br_valid  = 1'b1;
    bif.br_taken  = 1'b1;
    bif.br_is_rel = is_rel;
    bif.br_src_pc = src;
    bif.br_offset = off;
    bif.br_target = tgt;
    checks++;
    if (bif.br_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b required 1", name, bif.br_ready);
    end
    tick();
    exp_taken++;
    idle_inputs();
    bif.br_src_pc = 64'hDEAD_BEEF;
    bif.br_target = 64'hBAD0;
    checks++;
    if (pc_branch !== exp_pc || redirect !== 1'b1 || flush !== 1'b1 || bif.br_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_redirect: got pc=%h rd=%b fl=%b rdy=%b required pc=%h rd=1 fl=1 rdy=0",
               name, pc_branch, redirect, flush, bif.br_ready, exp_pc);
    end
  endtask

  task automatic drain();
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst  = 1'b1;
    pc_1 = 64'd5;
    tick();
    tick();
    checks++;
    if (pc_branch !== 64'd5 || flush !== 1'b0 || redirect !== 1'b0 || bif.br_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%h fl=%b rd=%b rdy=%b required pc=5 fl=0 rd=0 rdy=0",
               pc_branch, flush, redirect, bif.br_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bif.br_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", bif.br_ready);
    end
    exp_taken     = 0;
    exp_not_taken = 0;
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_taken !== 32'd0 || stat_not_taken !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got t=%0d nt=%0d required 0 0", stat_taken, stat_not_taken);
    end
`endif
  endtask

  task automatic test_rel_taken();
    pc_1 = 64'd20;
    taken_branch(1'b1, 64'd10, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd6, "rel");
    tick();
    checks++;
    if (flush !== 1'b1 || redirect !== 1'b0 || pc_branch !== 64'd20 || bif.br_ready !== 1'b0) begin
      errors++;
      $display("FAIL rel_flush1: got fl=%b rd=%b pc=%h rdy=%b required fl=1 rd=0 pc=14 rdy=0",
               flush, redirect, pc_branch, bif.br_ready);
    end
    pc_1 = 64'd24;
    tick();
    checks++;
    if (flush !== 1'b1 || redirect !== 1'b0 || pc_branch !== 64'd24 || bif.br_ready !== 1'b0) begin
      errors++;
      $display("FAIL rel_flush2: got fl=%b rd=%b pc=%h rdy=%b required fl=1 rd=0 pc=18 rdy=0",
               flush, redirect, pc_branch, bif.br_ready);
    end
    tick();
    checks++;
    if (flush !== 1'b0 || redirect !== 1'b0 || pc_branch !== 64'd24 || bif.br_ready !== 1'b1) begin
      errors++;
      $display("FAIL rel_idle: got fl=%b rd=%b pc=%h rdy=%b required fl=0 rd=0 pc=18 rdy=1",
               flush, redirect, pc_branch, bif.br_ready);
    end
  endtask

  task automatic test_abs_wrap();
    pc_1 = 64'd40;
    taken_branch(1'b0, 64'd7, 64'd9, 64'h100, 64'h100, "abs");
    drain();
    taken_branch(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h55, 64'd1, "wrap");
    drain();
    pc_1 = 64'h200;
    taken_branch(1'b0, 64'd0, 64'd0, 64'h200, 64'h200, "same_pc");
    drain();
  endtask

  task automatic test_not_taken();
    logic [63:0] pcs [3];
    pcs[0] = 64'h1000;
    pcs[1] = 64'h1004;
    pcs[2] = 64'h1008;
    for (int i = 0; i < 3; i++) begin
      pc_1          = pcs[i];
      bif.br_valid  = 1'b1;
      bif.br_taken  = 1'b0;
      bif.br_is_rel = 1'b0;
      bif.br_target = 64'h9999;
      tick();
      exp_not_taken++;
      checks++;
      if (flush !== 1'b0 || redirect !== 1'b0 || bif.br_ready !== 1'b1 || pc_branch !== pcs[i]) begin
        errors++;
        $display("FAIL not_taken_%0d: got fl=%b rd=%b rdy=%b pc=%h required fl=0 rd=0 rdy=1 pc=%h",
                 i, flush, redirect, bif.br_ready, pc_branch, pcs[i]);
      end
    end
    idle_inputs();
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_not_taken !== 32'(exp_not_taken) || stat_taken !== 32'(exp_taken)) begin
      errors++;
      $display("FAIL not_taken_stats: got t=%0d nt=%0d required t=%0d nt=%0d",
               stat_taken, stat_not_taken, exp_taken, exp_not_taken);
    end
`endif
  endtask

  task automatic test_stall();
    int waited;
    bit ok;
    pc_1 = 64'h3000;
    taken_branch(1'b0, 64'd0, 64'd0, 64'h80, 64'h80, "stall_first");
    bif.br_valid  = 1'b1;
    bif.br_taken  = 1'b1;
    bif.br_is_rel = 1'b0;
    bif.br_target = 64'h40;
    waited = 0;
    ok     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bif.br_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
      checks++;
      if (redirect !== 1'b0 || flush !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got rd=%b fl=%b required rd=0 fl=1", i, redirect, flush);
      end
    end
    checks++;
    if (!ok || waited != 2) begin
      errors++;
      $display("FAIL stall_wait: got %0d blocked cycles (ready seen=%b) required 2", waited, ok);
    end
    tick();
    exp_taken++;
    idle_inputs();
    checks++;
    if (pc_branch !== 64'h40 || redirect !== 1'b1 || flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_redirect: got pc=%h rd=%b fl=%b required pc=40 rd=1 fl=1",
               pc_branch, redirect, flush);
    end
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_taken !== 32'(exp_taken)) begin
      errors++;
      $display("FAIL stall_stats: got t=%0d required %0d", stat_taken, exp_taken);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid_flush();
    pc_1 = 64'h4000;
    taken_branch(1'b0, 64'd0, 64'd0, 64'h123, 64'h123, "rmf");
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b0 || bif.br_ready !== 1'b0 || pc_branch !== 64'h4000) begin
      errors++;
      $display("FAIL rmf_during_rst: got fl=%b rdy=%b pc=%h required fl=0 rdy=0 pc=4000",
               flush, bif.br_ready, pc_branch);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || redirect !== 1'b0 || bif.br_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmf_idle: got fl=%b rd=%b rdy=%b required fl=0 rd=0 rdy=1",
               flush, redirect, bif.br_ready);
    end
    tick();
    checks++;
    if (flush !== 1'b0 || redirect !== 1'b0 || bif.br_ready !== 1'b1 || pc_branch !== 64'h4000) begin
      errors++;
      $display("FAIL rmf_stays_idle: got fl=%b rd=%b rdy=%b pc=%h required fl=0 rd=0 rdy=1 pc=4000",
               flush, redirect, bif.br_ready, pc_branch);
    end
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_taken !== 32'd0 || stat_not_taken !== 32'd0) begin
      errors++;
      $display("FAIL rmf_stats: got t=%0d nt=%0d required 0 0", stat_taken, stat_not_taken);
    end
`endif
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    exp_taken     = 0;
    exp_not_taken = 0;
    rst           = 1'b1;
    pc_1          = 64'd0;
    idle_inputs();
    test_reset();
    test_rel_taken();
    test_abs_wrap();
    test_not_taken();
    test_stall();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
